// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD geometry, colour type and write-arbiter states
package lcd_pkg;

   localparam int unsigned LCD_W      = 160;
   localparam int unsigned LCD_H      = 144;
   localparam int unsigned LCD_PIXELS = LCD_W * LCD_H;

   typedef logic [14:0] pixel_color_t;

   localparam pixel_color_t COLOR_WHITE = 15'h7fff;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } lcd_wr_state_t;

endpackage

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - framebuffer write-port owner: PPU pixel writes vs. white-fill sweep
module lcd_write_arbiter
   import lcd_pkg::*;
#(
   parameter int unsigned  PIXELS     = LCD_PIXELS,
   parameter int unsigned  ADDR_W     = 16,
   parameter pixel_color_t FILL_COLOR = COLOR_WHITE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              slow_clk_en,
   input  logic              ppu_enable,
   input  logic [ADDR_W-1:0] pix_num,
   input  logic [14:0]       pix_color,
   input  logic              pix_write,
   output logic [ADDR_W-1:0] fb_waddr,
   output logic [14:0]       fb_wdata,
   output logic              fb_wren,
   output logic              clearing,
   output logic              clear_done,
   output logic              range_err
);

   if (PIXELS == 0 || (64'(PIXELS) - 64'd1) > ((64'd1 << ADDR_W) - 64'd1)) begin : g_bad_size
      $error("lcd_write_arbiter: PIXELS-1 does not fit in ADDR_W bits");
   end

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   lcd_wr_state_t     state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              ppu_q;
   logic              reset_sweep_q;

   logic              ppu_wr;
   logic              ppu_fall;
   logic              pix_in_range;
   logic [ADDR_W-1:0] sweep_addr;

   assign ppu_wr       = slow_clk_en & pix_write & ppu_enable;
   assign ppu_fall     = ppu_q & ~ppu_enable;
   assign pix_in_range = (pix_num <= LAST_ADDR);
   // A falling edge seen mid-sweep restarts the fill from address 0 in the same cycle.
   assign sweep_addr   = ppu_fall ? '0 : cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= CLEAR;
         cnt_q         <= '0;
         ppu_q         <= 1'b0;
         reset_sweep_q <= 1'b1;
         fb_waddr      <= '0;
         fb_wdata      <= '0;
         fb_wren       <= 1'b0;
         clearing      <= 1'b0;
         clear_done    <= 1'b0;
         range_err     <= 1'b0;
      end else begin
         ppu_q      <= ppu_enable;
         fb_wren    <= 1'b0;
         clear_done <= 1'b0;

         // PPU writes win the port in IDLE and CLEAR; DONE ignores them.
         if (ppu_wr && state_q != DONE) begin
            if (pix_in_range) begin
               fb_wren  <= 1'b1;
               fb_waddr <= pix_num;
               fb_wdata <= pix_color;
            end else begin
               range_err <= 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               clearing <= 1'b0;
               if (ppu_fall) begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
               end
            end

            CLEAR: begin
               if (ppu_enable && !reset_sweep_q) begin
                  state_q  <= IDLE;
                  cnt_q    <= '0;
                  clearing <= 1'b0;
               end else if (ppu_wr && pix_in_range) begin
                  // Reset sweep yields this cycle to the PPU and holds its counter.
                  clearing <= 1'b1;
               end else begin
                  fb_wren  <= 1'b1;
                  fb_waddr <= sweep_addr;
                  fb_wdata <= FILL_COLOR;
                  clearing <= 1'b1;
                  if (sweep_addr == LAST_ADDR) begin
                     clear_done    <= 1'b1;
                     state_q       <= DONE;
                     cnt_q         <= '0;
                     reset_sweep_q <= 1'b0;
                  end else begin
                     cnt_q <= sweep_addr + ADDR_W'(1);
                  end
               end
            end

            DONE: begin
               clearing <= 1'b0;
               if (ppu_enable) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q  <= CLEAR;
               cnt_q    <= '0;
               clearing <= 1'b0;
            end
         endcase
      end
   end

endmodule
